// File: rtl/sram_arbiter.sv
// Shares one SRAM-like memory port between the instruction-fetch and data masters.
// Address-phase arbitration with a grant lock; in-order responses are routed back via a source-tag FIFO.
module sram_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int OUTS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,

  input  logic              inst_sram_req,
  input  logic              inst_sram_wr,
  input  logic [1:0]        inst_sram_size,
  input  logic [3:0]        inst_sram_wstrb,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [DATA_W-1:0] inst_sram_wdata,
  output logic              inst_sram_addr_ok,
  output logic              inst_sram_data_ok,
  output logic [DATA_W-1:0] inst_sram_rdata,

  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [3:0]        data_sram_wstrb,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [DATA_W-1:0] data_sram_rdata,

  output logic              mem_sram_req,
  output logic              mem_sram_wr,
  output logic [1:0]        mem_sram_size,
  output logic [3:0]        mem_sram_wstrb,
  output logic [ADDR_W-1:0] mem_sram_addr,
  output logic [DATA_W-1:0] mem_sram_wdata,
  input  logic              mem_sram_addr_ok,
  input  logic              mem_sram_data_ok,
  input  logic [DATA_W-1:0] mem_sram_rdata
);

  localparam int PTR_W = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUTS_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(OUTS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTS_DEPTH - 1);

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  logic                  active_q;
  logic                  lockValid_q, lockValid_d;
  src_e                  lockSrc_q, lockSrc_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
  logic [OUTS_DEPTH-1:0] tags_q, tags_d;

  src_e sel;
  src_e head;
  logic full;
  logic selReq;
  logic memReq;
  logic handshake;
  logic pop;

  function automatic logic [PTR_W-1:0] ptrNext(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // A held grant wins over priority; otherwise the data master has fixed priority.
  always_comb begin
    sel = SRC_INST;
    if (lockValid_q)
      sel = lockSrc_q;
    else if (data_sram_req)
      sel = SRC_DATA;
  end

  assign full      = (count_q == DEPTH_C);
  assign selReq    = (sel == SRC_DATA) ? data_sram_req : inst_sram_req;
  assign memReq    = active_q & ~full & selReq;
  assign handshake = memReq & mem_sram_addr_ok;
  assign pop       = active_q & mem_sram_data_ok & (count_q != '0);
  assign head      = src_e'(tags_q[rdPtr_q]);

  // active_q keeps every output quiet until the first clock edge after reset release.
  assign mem_sram_req   = memReq;
  assign mem_sram_wr    = active_q & ((sel == SRC_DATA) ? data_sram_wr : inst_sram_wr);
  assign mem_sram_size  = active_q ? ((sel == SRC_DATA) ? data_sram_size  : inst_sram_size)  : '0;
  assign mem_sram_wstrb = active_q ? ((sel == SRC_DATA) ? data_sram_wstrb : inst_sram_wstrb) : '0;
  assign mem_sram_addr  = active_q ? ((sel == SRC_DATA) ? data_sram_addr  : inst_sram_addr)  : '0;
  assign mem_sram_wdata = active_q ? ((sel == SRC_DATA) ? data_sram_wdata : inst_sram_wdata) : '0;

  assign inst_sram_addr_ok = handshake & (sel == SRC_INST);
  assign data_sram_addr_ok = handshake & (sel == SRC_DATA);
  assign inst_sram_data_ok = pop & (head == SRC_INST);
  assign data_sram_data_ok = pop & (head == SRC_DATA);
  assign inst_sram_rdata   = active_q ? mem_sram_rdata : '0;
  assign data_sram_rdata   = active_q ? mem_sram_rdata : '0;

  always_comb begin
    lockValid_d = lockValid_q;
    lockSrc_d   = lockSrc_q;
    count_d     = count_q;
    rdPtr_d     = rdPtr_q;
    wrPtr_d     = wrPtr_q;
    tags_d      = tags_q;

    if (handshake) begin
      lockValid_d = 1'b0;
    end else if (memReq) begin
      lockValid_d = 1'b1;
      lockSrc_d   = sel;
    end

    if (handshake) begin
      tags_d[wrPtr_q] = sel;
      wrPtr_d         = ptrNext(wrPtr_q);
    end
    if (pop)
      rdPtr_d = ptrNext(rdPtr_q);

    case ({handshake, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      active_q    <= 1'b0;
      lockValid_q <= 1'b0;
      lockSrc_q   <= SRC_INST;
      count_q     <= '0;
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      tags_q      <= '0;
    end else begin
      active_q    <= 1'b1;
      lockValid_q <= lockValid_d;
      lockSrc_q   <= lockSrc_d;
      count_q     <= count_d;
      rdPtr_q     <= rdPtr_d;
      wrPtr_q     <= wrPtr_d;
      tags_q      <= tags_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based model of the arbiter.
module tb_sram_arbiter;

  localparam int OUTS = 4;

  logic        clk;
  logic        resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        mem_sram_req, mem_sram_wr;
  logic [1:0]  mem_sram_size;
  logic [3:0]  mem_sram_wstrb;
  logic [31:0] mem_sram_addr, mem_sram_wdata;
  logic        mem_sram_addr_ok, mem_sram_data_ok;
  logic [31:0] mem_sram_rdata;

  int checks = 0;
  int errors = 0;

  // Model state: outstanding source tags in issue order (0=inst, 1=data),
  // the master holding the address phase (-1 = none), and the post-reset quiet flag.
  int tagQ[$];
  int lockSrc = -1;
  bit ready   = 0;
  bit lastIAok, lastDAok;
  bit iPend, dPend;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .OUTS_DEPTH(OUTS)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .mem_sram_req(mem_sram_req), .mem_sram_wr(mem_sram_wr), .mem_sram_size(mem_sram_size),
    .mem_sram_wstrb(mem_sram_wstrb), .mem_sram_addr(mem_sram_addr), .mem_sram_wdata(mem_sram_wdata),
    .mem_sram_addr_ok(mem_sram_addr_ok), .mem_sram_data_ok(mem_sram_data_ok), .mem_sram_rdata(mem_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearInputs();
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 0; inst_sram_wstrb = 0;
    inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_wstrb = 0;
    data_sram_addr = 0; data_sram_wdata = 0;
    mem_sram_addr_ok = 0; mem_sram_data_ok = 0; mem_sram_rdata = 0;
  endtask

  // Compares every DUT output with the model for the current inputs, then advances the model
  // to the state the coming clock edge will produce.
  task automatic checkOutput();
    int  sel, head;
    bit  selReq, expReq, hs, pop;
    logic [31:0] expAddr, expWdata;
    logic [1:0]  expSize;
    logic [3:0]  expWstrb;
    bit          expWr;
    if (!resetn) begin
      tagQ.delete();
      lockSrc = -1;
      ready   = 0;
    end
    sel    = (lockSrc >= 0) ? lockSrc : (data_sram_req ? 1 : 0);
    selReq = sel ? data_sram_req : inst_sram_req;
    expReq = ready && (tagQ.size() < OUTS) && selReq;
    hs     = expReq && mem_sram_addr_ok;
    pop    = ready && mem_sram_data_ok && (tagQ.size() > 0);
    head   = pop ? tagQ[0] : -1;
    expWr    = ready && (sel ? data_sram_wr : inst_sram_wr);
    expSize  = ready ? (sel ? data_sram_size  : inst_sram_size)  : 2'd0;
    expWstrb = ready ? (sel ? data_sram_wstrb : inst_sram_wstrb) : 4'd0;
    expAddr  = ready ? (sel ? data_sram_addr  : inst_sram_addr)  : 32'd0;
    expWdata = ready ? (sel ? data_sram_wdata : inst_sram_wdata) : 32'd0;

    check("mem_req",      mem_sram_req,      expReq);
    check("mem_wr",       mem_sram_wr,       expWr);
    check("mem_size",     mem_sram_size,     expSize);
    check("mem_wstrb",    mem_sram_wstrb,    expWstrb);
    check("mem_addr",     mem_sram_addr,     expAddr);
    check("mem_wdata",    mem_sram_wdata,    expWdata);
    check("inst_addr_ok", inst_sram_addr_ok, hs && sel == 0);
    check("data_addr_ok", data_sram_addr_ok, hs && sel == 1);
    check("inst_data_ok", inst_sram_data_ok, head == 0);
    check("data_data_ok", data_sram_data_ok, head == 1);
    check("inst_rdata",   inst_sram_rdata,   ready ? mem_sram_rdata : 32'd0);
    check("data_rdata",   data_sram_rdata,   ready ? mem_sram_rdata : 32'd0);

    lastIAok = hs && sel == 0;
    lastDAok = hs && sel == 1;
    if (resetn) begin
      if (pop) void'(tagQ.pop_front());
      if (hs) tagQ.push_back(sel);
      if (hs) lockSrc = -1;
      else if (expReq) lockSrc = sel;
      ready = 1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Legal random masters: a request and its fields stay put until the arbiter accepts it.
  task automatic applyStimulus();
    if (lastIAok) begin inst_sram_req = 0; iPend = 0; end
    if (lastDAok) begin data_sram_req = 0; dPend = 0; end
    if (!iPend && $urandom_range(0, 2) == 0) begin
      iPend = 1;
      inst_sram_req   = 1;
      inst_sram_wr    = 0;
      inst_sram_size  = 2'd2;
      inst_sram_wstrb = 4'h0;
      inst_sram_addr  = $urandom & 32'hffff_fffc;
      inst_sram_wdata = $urandom;
    end
    if (!dPend && $urandom_range(0, 2) == 0) begin
      dPend = 1;
      data_sram_req   = 1;
      data_sram_wr    = 1'($urandom_range(0, 1));
      data_sram_size  = 2'($urandom_range(0, 2));
      data_sram_wstrb = 4'($urandom_range(0, 15));
      data_sram_addr  = $urandom;
      data_sram_wdata = $urandom;
    end
    mem_sram_addr_ok = 1'($urandom_range(0, 1));
    mem_sram_data_ok = ($urandom_range(0, 2) == 0);
    mem_sram_rdata   = $urandom;
  endtask

  // Issues a single handshake from one master with memory accepting immediately.
  task automatic issueOne(input bit isData, input logic [31:0] addr);
    if (isData) begin data_sram_req = 1; data_sram_addr = addr; end
    else begin inst_sram_req = 1; inst_sram_addr = addr; end
    mem_sram_addr_ok = 1;
    settle();
    check(isData ? "issue_data_addr_ok" : "issue_inst_addr_ok",
          isData ? data_sram_addr_ok : inst_sram_addr_ok, 1);
    advance();
    clearInputs();
  endtask

  task automatic respond(input logic [31:0] rdata, input bit toData, input string name);
    mem_sram_data_ok = 1;
    mem_sram_rdata   = rdata;
    settle();
    check({name, "_ok"},    toData ? data_sram_data_ok : inst_sram_data_ok, 1);
    check({name, "_other"}, toData ? inst_sram_data_ok : data_sram_data_ok, 0);
    check({name, "_rdata"}, toData ? data_sram_rdata : inst_sram_rdata, rdata);
    advance();
    clearInputs();
  endtask

  initial begin
    clearInputs();
    resetn = 0;
    inst_sram_req = 1;
    data_sram_req = 1;
    settle();
    check("rst_mem_req", mem_sram_req, 0);
    check("rst_data_addr_ok", data_sram_addr_ok, 0);
    advance();
    resetn = 1;
    settle();
    check("post_rst_mem_req", mem_sram_req, 0);
    advance();
    clearInputs();

    // Single inst read with a two-cycle response.
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0000; mem_sram_addr_ok = 1;
    settle();
    check("t1_addr", mem_sram_addr, 32'h1c00_0000);
    check("t1_inst_addr_ok", inst_sram_addr_ok, 1);
    advance();
    clearInputs();
    settle();
    advance();
    respond(32'h0280_0c0c, 0, "t1_resp");

    // Simultaneous requests: data first, inst the next cycle.
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0004;
    data_sram_req = 1; data_sram_addr = 32'h8000_0010; data_sram_wr = 1; data_sram_wstrb = 4'hf;
    mem_sram_addr_ok = 1;
    settle();
    check("t2_data_addr_ok", data_sram_addr_ok, 1);
    check("t2_inst_addr_ok", inst_sram_addr_ok, 0);
    check("t2_addr", mem_sram_addr, 32'h8000_0010);
    advance();
    data_sram_req = 0;
    settle();
    check("t2_inst_second", inst_sram_addr_ok, 1);
    advance();
    clearInputs();
    respond(32'h0000_00aa, 1, "t2_resp_data");
    respond(32'h0000_00bb, 0, "t2_resp_inst");

    // Grant lock: stalled inst keeps the port although data has priority.
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_0100;
    for (int c = 0; c < 4; c++) begin
      if (c >= 1) begin data_sram_req = 1; data_sram_addr = 32'h8000_0200; end
      mem_sram_addr_ok = (c == 3);
      settle();
      check("t3_locked_addr", mem_sram_addr, 32'h1c00_0100);
      check("t3_data_blocked", data_sram_addr_ok, 0);
      advance();
    end
    inst_sram_req = 0;
    mem_sram_addr_ok = 1;
    settle();
    check("t3_data_after", data_sram_addr_ok, 1);
    advance();
    clearInputs();
    respond(32'h0000_0001, 0, "t3_resp_inst");
    respond(32'h0000_0002, 1, "t3_resp_data");

    // Fill to depth, then verify full blocks even with a simultaneous pop.
    for (int k = 0; k < OUTS; k++) issueOne(0, 32'h1c00_1000 + 32'(k * 4));
    inst_sram_req = 1; inst_sram_addr = 32'h1c00_2000; mem_sram_addr_ok = 1;
    settle();
    check("t4_full_req", mem_sram_req, 0);
    advance();
    mem_sram_data_ok = 1; mem_sram_rdata = 32'h5;
    settle();
    check("t4_full_pop_req", mem_sram_req, 0);
    check("t4_full_pop_aok", inst_sram_addr_ok, 0);
    check("t4_full_pop_dok", inst_sram_data_ok, 1);
    advance();
    mem_sram_data_ok = 0;
    settle();
    check("t4_after_pop_req", mem_sram_req, 1);
    check("t4_after_pop_aok", inst_sram_addr_ok, 1);
    advance();
    clearInputs();
    for (int k = 0; k < OUTS; k++) respond(32'(k), 0, "t4_drain");

    // Response ordering follows issue order.
    issueOne(0, 32'h1c00_3000);
    issueOne(1, 32'h8000_3000);
    issueOne(0, 32'h1c00_3004);
    respond(32'h11, 0, "t5_first");
    respond(32'h22, 1, "t5_second");
    respond(32'h33, 0, "t5_third");

    // Reset with outstanding tags, then a stray response.
    issueOne(0, 32'h1c00_4000);
    issueOne(1, 32'h8000_4000);
    resetn = 0;
    inst_sram_req = 1; mem_sram_data_ok = 1;
    settle();
    check("t6_rst_mem_req", mem_sram_req, 0);
    check("t6_rst_inst_dok", inst_sram_data_ok, 0);
    advance();
    resetn = 1;
    clearInputs();
    settle();
    advance();
    mem_sram_data_ok = 1; mem_sram_rdata = 32'hdead_beef;
    settle();
    check("t6_spurious_inst", inst_sram_data_ok, 0);
    check("t6_spurious_data", data_sram_data_ok, 0);
    advance();
    clearInputs();

    // Random traffic with one mid-run reset.
    iPend = 0; dPend = 0; lastIAok = 0; lastDAok = 0;
    for (int i = 0; i < 3000; i++) begin
      resetn = (i != 1500);
      applyStimulus();
      settle();
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
